// File: rtl/picomips_loader_pkg.sv
// Shared types and defaults for the picoMIPS operand loader.
//   loader_state_t    : loader FSM states
//   DB_CYCLES_DEFAULT : default debounce length in clk cycles
package picomips_loader_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,  // waiting for a load press
        WRITE   = 2'd1,  // one-cycle register-file write strobe
        RELEASE = 2'd2,  // waiting for the load switch to return low
        DONE    = 2'd3   // all operands written, CPU released
    } loader_state_t;

    localparam int DB_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus counter debouncer for one bouncy switch.
//   clk   in  : system clock
//   rst   in  : asynchronous active-high reset
//   din   in  : raw asynchronous switch level
//   level out : debounced level, changes only after DB_CYCLES stable samples
//   rise  out : registered one-cycle pulse on a 0->1 change of level
module sw_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise
);

    localparam int CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    // The counter tracks how many consecutive samples of s2 disagree with
    // level; DB_CYCLES disagreeing samples in a row commit the new level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
                // level is about to take s2, so s2 high means a rising change
                rise  <= s2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sw_operand_loader.sv
// Loads NWORDS operand bytes from the board switches into the picoMIPS
// register file, one byte per debounced press of the load switch, and keeps
// the CPU stalled until the last operand has been written.
//   clk       in  : system clock
//   reset     in  : asynchronous active-high reset
//   sw_data   in  : raw operand switches
//   sw_load   in  : raw, bouncy load switch
//   wr_en     out : register-file write strobe, one cycle per operand
//   wr_addr   out : destination register (BASE + word index)
//   wr_data   out : captured operand byte
//   word_idx  out : operands loaded so far (0..NWORDS)
//   busy      out : loading incomplete
//   cpu_run   out : CPU released once all operands are written
//   fsm_state out : current loader state, for observation
// Write port protocol: wr_addr/wr_data are valid whenever wr_en is high; the
// register file has no back-pressure, so each wr_en cycle is one accepted write.
module sw_operand_loader
    import picomips_loader_pkg::*;
#(
    parameter int n         = 8,
    parameter int AW        = 5,
    parameter int NWORDS    = 4,
    parameter int BASE      = 1,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    localparam int IW       = $clog2(NWORDS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [n-1:0]  sw_data,
    input  logic          sw_load,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [n-1:0]  wr_data,
    output logic [IW-1:0] word_idx,
    output logic          busy,
    output logic          cpu_run,
    output loader_state_t fsm_state
);

    logic [n-1:0]  data_s1;
    logic [n-1:0]  data_s2;
    logic          load_level;
    logic          press;
    logic          capture;
    loader_state_t state;
    loader_state_t state_next;

    sw_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_load_db (
        .clk   (clk),
        .rst   (reset),
        .din   (sw_load),
        .level (load_level),
        .rise  (press)
    );

    // Operand switches only need metastability protection: they are sampled
    // on a debounced press, long after they have settled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            data_s1 <= sw_data;
            data_s2 <= data_s1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= COLLECT;
            word_idx <= '0;
            wr_addr  <= AW'(BASE);
            wr_data  <= '0;
        end else begin
            state <= state_next;
            // Address and data are held from capture until the next capture,
            // so they are stable across the whole WRITE cycle.
            if (capture) begin
                wr_addr <= AW'(BASE) + AW'(word_idx);
                wr_data <= data_s2;
            end
            if (state == WRITE) begin
                word_idx <= word_idx + IW'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            COLLECT: begin
                if (press) begin
                    capture    = 1'b1;
                    state_next = WRITE;
                end
            end
            WRITE: begin
                // word_idx is incremented on this same edge
                if (word_idx == IW'(NWORDS - 1)) begin
                    state_next = DONE;
                end else begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (!load_level) begin
                    state_next = COLLECT;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = COLLECT;
            end
        endcase
    end

    assign wr_en     = (state == WRITE);
    assign cpu_run   = (state == DONE);
    assign busy      = ~cpu_run;
    assign fsm_state = state;

endmodule

// File: tb/tb_sw_operand_loader.sv
module tb_sw_operand_loader;
    import picomips_loader_pkg::*;

    localparam int N      = 8;
    localparam int AW     = 5;
    localparam int NWORDS = 4;
    localparam int BASE   = 1;
    localparam int DB     = 4;
    localparam int IW     = $clog2(NWORDS + 1);

    logic          clk;
    logic          reset;
    logic [N-1:0]  sw_data;
    logic          sw_load;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic [IW-1:0] word_idx;
    logic          busy;
    logic          cpu_run;
    loader_state_t fsm_state;

    int errors;
    int checks;
    int wr_count;

    // expected writes: {addr, data}
    logic [AW+N-1:0] exp_q[$];
    logic [AW+N-1:0] sb_e;

    sw_operand_loader #(
        .n         (N),
        .AW        (AW),
        .NWORDS    (NWORDS),
        .BASE      (BASE),
        .DB_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_data   (sw_data),
        .sw_load   (sw_load),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .word_idx  (word_idx),
        .busy      (busy),
        .cpu_run   (cpu_run),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboard: every write strobe must match the next expected write
    always @(negedge clk) begin
        if (reset === 1'b0 && wr_en === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_addr", 32'(wr_addr), 32'(sb_e[AW+N-1:N]));
                check("sb_data", 32'(wr_data), 32'(sb_e[N-1:0]));
            end
        end
    end

    // driver tasks (all leave time at posedge + 1)
    task automatic tick(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
    endtask

    // Press with cycle-exact checks: the strobe appears 7 cycles after the
    // load switch rises (2 sync + 4 debounce + 1 FSM).
    task automatic press_timed(input logic [N-1:0] d, input logic [AW-1:0] addr, input bit last);
        exp_q.push_back({addr, d});
        sw_data = d;
        sw_load = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 6) check("pre_strobe_wr_en", 32'(wr_en), 32'd0);
            if (i == 7) begin
                check("strobe_wr_en", 32'(wr_en), 32'd1);
                check("strobe_addr", 32'(wr_addr), 32'(addr));
                check("strobe_data", 32'(wr_data), 32'(d));
                check("strobe_cpu_run", 32'(cpu_run), 32'd0);
            end
            if (i == 8) begin
                check("post_strobe_wr_en", 32'(wr_en), 32'd0);
                check("post_strobe_cpu_run", 32'(cpu_run), 32'(last));
                check("post_strobe_busy", 32'(busy), 32'(!last));
            end
        end
        tick(1);
        // data changes during RELEASE must not disturb the held byte
        sw_data = ~d;
        tick(10);
        sw_load = 1'b0;
        tick(10);
    endtask

    task automatic press_word(input logic [N-1:0] d);
        sw_data = d;
        sw_load = 1'b1;
        tick(12);
        sw_load = 1'b0;
        tick(10);
    endtask

    int base_cnt;

    initial begin
        errors   = 0;
        checks   = 0;
        wr_count = 0;
        reset    = 1'b1;
        sw_data  = '0;
        sw_load  = 1'b0;

        // 1: reset state
        #12;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_word_idx", 32'(word_idx), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd1);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(2);

        // 2: clean load of 3C to reg 1
        press_timed(8'h3C, 5'd1, 1'b0);
        check("clean_word_idx", 32'(word_idx), 32'd1);
        check("clean_wr_data_held", 32'(wr_data), 32'h3C);
        check("clean_count", 32'(wr_count), 32'd1);

        // 3: bouncing press gives exactly one write to reg 2
        base_cnt = wr_count;
        exp_q.push_back({5'd2, 8'h5A});
        sw_data = 8'h5A;
        sw_load = 1'b1; tick(1);
        sw_load = 1'b0; tick(1);
        sw_load = 1'b1; tick(1);
        sw_load = 1'b0; tick(1);
        sw_load = 1'b1; tick(14);
        sw_load = 1'b0; tick(10);
        check("bounce_count", 32'(wr_count - base_cnt), 32'd1);
        check("bounce_word_idx", 32'(word_idx), 32'd2);
        // 3-cycle glitch alone must not register
        sw_data = 8'hEE;
        sw_load = 1'b1; tick(3);
        sw_load = 1'b0; tick(12);
        check("glitch_count", 32'(wr_count - base_cnt), 32'd1);
        check("glitch_word_idx", 32'(word_idx), 32'd2);

        // 4: full sequence from reset
        do_reset();
        check("seq_start_idx", 32'(word_idx), 32'd0);
        press_timed(8'h05, 5'd1, 1'b0);
        press_timed(8'h0A, 5'd2, 1'b0);
        press_timed(8'hF0, 5'd3, 1'b0);
        check("seq_busy_before_last", 32'(busy), 32'd1);
        press_timed(8'h7F, 5'd4, 1'b1);
        check("seq_word_idx", 32'(word_idx), 32'd4);
        check("seq_cpu_run", 32'(cpu_run), 32'd1);
        check("seq_state", 32'(fsm_state), 32'(DONE));

        // 5: DONE lock
        base_cnt = wr_count;
        press_word(8'hFF);
        press_word(8'h11);
        check("lock_count", 32'(wr_count - base_cnt), 32'd0);
        check("lock_word_idx", 32'(word_idx), 32'd4);
        check("lock_cpu_run", 32'(cpu_run), 32'd1);
        check("lock_wr_addr", 32'(wr_addr), 32'd4);
        check("lock_wr_data", 32'(wr_data), 32'h7F);

        // 6: reset mid-load
        do_reset();
        exp_q.push_back({5'd1, 8'hA1});
        press_word(8'hA1);
        exp_q.push_back({5'd2, 8'hB2});
        press_word(8'hB2);
        check("mid_idx_before", 32'(word_idx), 32'd2);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check("mid_rst_idx", 32'(word_idx), 32'd0);
        check("mid_rst_wr_addr", 32'(wr_addr), 32'd1);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_cpu_run", 32'(cpu_run), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        tick(2);
        press_timed(8'hC3, 5'd1, 1'b0);
        press_timed(8'hD4, 5'd2, 1'b0);
        press_timed(8'hE5, 5'd3, 1'b0);
        press_timed(8'hF6, 5'd4, 1'b1);
        check("reload_word_idx", 32'(word_idx), 32'd4);
        check("reload_cpu_run", 32'(cpu_run), 32'd1);

        // all expected writes observed
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("total_writes", 32'(wr_count), 32'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
